// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB pipeline stage: result select, load funct3 codes
// and the default data path width.
package mem_wb_stage_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Combinational load alignment: picks the byte/halfword addressed by addr_lo out of
// the raw memory word and sign- or zero-extends it to XLEN.
module load_extend
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfwords are addressed by addr_lo[1] only; misaligned offsets round down.
    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select and an optional retired-instruction
// counter built only when INSTRET_COUNTER_EN is defined (otherwise instret_o is 0).
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic                 reg_write_i,
    input  logic [4:0]           rd_i,
    input  logic [1:0]           result_src_i,
    input  logic [2:0]           funct3_i,
    input  logic [1:0]           addr_lo_i,
    input  logic [XLEN-1:0]      alu_result_i,
    input  logic [XLEN-1:0]      read_data_i,
    input  logic [XLEN-1:0]      pc_plus4_i,
    input  logic [XLEN-1:0]      imm_i,
    output logic                 wb_we_o,
    output logic [4:0]           wb_rd_o,
    output logic [XLEN-1:0]      wb_data_o,
    output logic                 wb_valid_o,
    output logic [INSTRET_W-1:0] instret_o
);

    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] result_d;
    logic [XLEN-1:0] data_q;
    logic            valid_q;
    logic            reg_write_q;
    logic [4:0]      rd_q;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .word    (read_data_i),
        .funct3  (funct3_i),
        .addr_lo (addr_lo_i),
        .data    (load_data)
    );

    always_comb begin
        result_d = alu_result_i;
        case (result_src_e'(result_src_i))
            RES_ALU: result_d = alu_result_i;
            RES_MEM: result_d = load_data;
            RES_PC4: result_d = pc_plus4_i;
            RES_IMM: result_d = imm_i;
            default: result_d = alu_result_i;
        endcase
    end

    // Flush beats stall: a squashed slot must never be held and re-presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else if (flush_i) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            data_q      <= '0;
        end else if (!stall_i) begin
            valid_q     <= valid_i;
            reg_write_q <= reg_write_i;
            rd_q        <= rd_i;
            data_q      <= result_d;
        end
    end

    assign wb_valid_o = valid_q;
    assign wb_rd_o    = rd_q;
    assign wb_we_o    = valid_q && reg_write_q && (rd_q != 5'd0);
    assign wb_data_o  = valid_q ? data_q : '0;

`ifdef INSTRET_COUNTER_EN
    logic [INSTRET_W-1:0] instret_q;

    // An instruction retires when it leaves the stage: valid, not held, not squashed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instret_q <= '0;
        end else if (valid_q && !stall_i && !flush_i) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the write-back stage.
module tb_mem_wb_stage;

    localparam int XLEN = 32;
    localparam int IW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall_i, flush_i, valid_i, reg_write_i;
    logic [4:0]      rd_i;
    logic [1:0]      result_src_i;
    logic [2:0]      funct3_i;
    logic [1:0]      addr_lo_i;
    logic [XLEN-1:0] alu_result_i, read_data_i, pc_plus4_i, imm_i;
    logic            wb_we_o, wb_valid_o;
    logic [4:0]      wb_rd_o;
    logic [XLEN-1:0] wb_data_o;
    logic [IW-1:0]   instret_o;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic            m_valid;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    int              m_cnt;

    mem_wb_stage #(.XLEN(XLEN), .INSTRET_W(IW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .reg_write_i  (reg_write_i),
        .rd_i         (rd_i),
        .result_src_i (result_src_i),
        .funct3_i     (funct3_i),
        .addr_lo_i    (addr_lo_i),
        .alu_result_i (alu_result_i),
        .read_data_i  (read_data_i),
        .pc_plus4_i   (pc_plus4_i),
        .imm_i        (imm_i),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_data_o    (wb_data_o),
        .wb_valid_o   (wb_valid_o),
        .instret_o    (instret_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int f3, input int off);
        logic [31:0] v;
        case (f3)
            0, 4: begin
                v = (word >> (8 * off)) & 32'hFF;
                if (f3 == 0 && v > 127) v = v - 32'd256;
            end
            1, 5: begin
                v = (word >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 1 && v > 32767) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [IW-1:0] exp_instret();
`ifdef INSTRET_COUNTER_EN
        return IW'(m_cnt);
`else
        return '0;
`endif
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_we    = 1'b0;
        m_rd    = 5'd0;
        m_data  = '0;
        m_cnt   = 0;
    endtask

    // Advance the model for the pending edge, then wait for it and settle.
    task automatic tick();
        logic [31:0] sel;
        if (m_valid && !stall_i && !flush_i) m_cnt = (m_cnt + 1) % (1 << IW);
        case (result_src_i)
            2'd0:    sel = alu_result_i;
            2'd1:    sel = ref_load(read_data_i, int'(funct3_i), int'(addr_lo_i));
            2'd2:    sel = pc_plus4_i;
            default: sel = imm_i;
        endcase
        if (flush_i) begin
            m_valid = 1'b0;
            m_we    = 1'b0;
            m_data  = '0;
        end else if (!stall_i) begin
            m_valid = valid_i;
            m_rd    = rd_i;
            m_we    = valid_i && reg_write_i && (rd_i != 5'd0);
            m_data  = valid_i ? sel : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic rw, input logic [4:0] rd, input logic [1:0] rs,
                             input logic [2:0] f3, input logic [1:0] al, input logic [31:0] alu,
                             input logic [31:0] rdata);
        valid_i      = 1'b1;
        reg_write_i  = rw;
        rd_i         = rd;
        result_src_i = rs;
        funct3_i     = f3;
        addr_lo_i    = al;
        alu_result_i = alu;
        read_data_i  = rdata;
        pc_plus4_i   = 32'h0000_1004;
        imm_i        = 32'hABCD_E000;
    endtask

    task automatic set_idle();
        stall_i = 1'b0;
        flush_i = 1'b0;
        valid_i = 1'b0;
        reg_write_i = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        set_instr(1'b1, 5'd3, 2'd0, 3'd2, 2'd0, 32'h1111_2222, 32'h0);
        valid_i = 1'b0;
        rst = 1'b0;
        model_clear();
        #7;
        n_total++; if (wb_valid_o !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", wb_valid_o); else n_pass++;
        n_total++; if (wb_we_o !== 1'b0) $display("FAIL reset_we got=%0b exp=0", wb_we_o); else n_pass++;
        n_total++; if (wb_data_o !== 32'h0) $display("FAIL reset_data got=%h exp=0", wb_data_o); else n_pass++;
        n_total++; if (instret_o !== '0) $display("FAIL reset_instret got=%0d exp=0", instret_o); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lb();
        set_idle();
        set_instr(1'b1, 5'd7, 2'd1, 3'd0, 2'd2, 32'h0, 32'h80FF_7F01);
        tick();
        n_total++; if (wb_data_o !== 32'hFFFF_FFFF) $display("FAIL lb_data got=%h exp=ffffffff", wb_data_o); else n_pass++;
        n_total++; if (wb_we_o !== 1'b1) $display("FAIL lb_we got=%0b exp=1", wb_we_o); else n_pass++;
        n_total++; if (wb_rd_o !== 5'd7) $display("FAIL lb_rd got=%0d exp=7", wb_rd_o); else n_pass++;
    endtask

    task automatic test_lhu();
        set_idle();
        set_instr(1'b1, 5'd9, 2'd1, 3'd5, 2'd3, 32'h0, 32'h80FF_7F01);
        tick();
        n_total++; if (wb_data_o !== 32'h0000_80FF) $display("FAIL lhu_data got=%h exp=000080ff", wb_data_o); else n_pass++;
        n_total++; if (wb_valid_o !== 1'b1) $display("FAIL lhu_valid got=%0b exp=1", wb_valid_o); else n_pass++;
    endtask

    task automatic test_x0_write();
        int c0;
        set_idle();
        set_instr(1'b1, 5'd0, 2'd0, 3'd2, 2'd0, 32'h1234_5678, 32'h0);
        tick();
        c0 = m_cnt;
        n_total++; if (wb_we_o !== 1'b0) $display("FAIL x0_we got=%0b exp=0", wb_we_o); else n_pass++;
        n_total++; if (wb_valid_o !== 1'b1) $display("FAIL x0_valid got=%0b exp=1", wb_valid_o); else n_pass++;
        n_total++; if (wb_data_o !== 32'h1234_5678) $display("FAIL x0_data got=%h exp=12345678", wb_data_o); else n_pass++;
        set_idle();
        tick();
        n_total++; if (m_cnt != (c0 + 1) % 16 || instret_o !== exp_instret())
            $display("FAIL x0_instret got=%0d exp=%0d", instret_o, exp_instret()); else n_pass++;
    endtask

    task automatic test_stall();
        logic [IW-1:0] held_cnt;
        set_idle();
        set_instr(1'b1, 5'd5, 2'd0, 3'd2, 2'd0, 32'hDEAD_BEEF, 32'h0);
        tick();
        held_cnt = exp_instret();
        for (int i = 0; i < 3; i++) begin
            stall_i = 1'b1;
            set_instr(1'b1, 5'($urandom_range(1, 31)), 2'd0, 3'd2, 2'd0, $urandom, $urandom);
            tick();
            n_total++; if (wb_data_o !== 32'hDEAD_BEEF || wb_we_o !== 1'b1 || wb_rd_o !== 5'd5)
                $display("FAIL stall_hold cyc=%0d got=%h/%0b/%0d exp=deadbeef/1/5", i, wb_data_o, wb_we_o, wb_rd_o);
            else n_pass++;
            n_total++; if (instret_o !== held_cnt)
                $display("FAIL stall_instret cyc=%0d got=%0d exp=%0d", i, instret_o, held_cnt); else n_pass++;
        end
        set_idle();
        tick();
        n_total++; if (instret_o !== exp_instret())
            $display("FAIL stall_release_instret got=%0d exp=%0d", instret_o, exp_instret()); else n_pass++;
    endtask

    task automatic test_stall_flush();
        set_idle();
        set_instr(1'b1, 5'd12, 2'd3, 3'd2, 2'd0, 32'h0, 32'h0);
        tick();
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        n_total++; if (wb_valid_o !== 1'b0) $display("FAIL flush_valid got=%0b exp=0", wb_valid_o); else n_pass++;
        n_total++; if (wb_we_o !== 1'b0) $display("FAIL flush_we got=%0b exp=0", wb_we_o); else n_pass++;
        n_total++; if (wb_data_o !== 32'h0) $display("FAIL flush_data got=%h exp=0", wb_data_o); else n_pass++;
        set_idle();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall_i      = ($urandom_range(0, 3) == 0);
            flush_i      = ($urandom_range(0, 9) == 0);
            valid_i      = ($urandom_range(0, 4) != 0);
            reg_write_i  = $urandom_range(0, 1);
            rd_i         = 5'($urandom_range(0, 31));
            result_src_i = 2'($urandom_range(0, 3));
            funct3_i     = 3'($urandom_range(0, 7));
            addr_lo_i    = 2'($urandom_range(0, 3));
            alu_result_i = $urandom;
            read_data_i  = $urandom;
            pc_plus4_i   = $urandom;
            imm_i        = $urandom;
            tick();
            n_total++; if (wb_valid_o !== m_valid || wb_we_o !== m_we || wb_data_o !== m_data ||
                           (m_valid && wb_rd_o !== m_rd) || instret_o !== exp_instret())
                $display("FAIL rand cyc=%0d got v%0b we%0b rd%0d d%h n%0d exp v%0b we%0b rd%0d d%h n%0d",
                         i, wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, instret_o,
                         m_valid, m_we, m_rd, m_data, exp_instret());
            else n_pass++;
        end
        set_idle();
        tick();
    endtask

    task automatic test_wrap();
        int guard = 0;
        set_idle();
        set_instr(1'b0, 5'd1, 2'd0, 3'd2, 2'd0, 32'h5, 32'h0);
        tick();
        while (m_cnt != 15 && guard < 40) begin
            tick();
            guard++;
        end
        n_total++; if (instret_o !== exp_instret())
            $display("FAIL wrap_preload got=%0d exp=%0d", instret_o, exp_instret()); else n_pass++;
        tick();
        n_total++; if (m_cnt != 0) $display("FAIL wrap_model got=%0d exp=0", m_cnt); else n_pass++;
        n_total++; if (instret_o !== '0) $display("FAIL wrap_instret got=%0d exp=0", instret_o); else n_pass++;
        set_idle();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_idle();
        set_instr(1'b1, 5'd21, 2'd2, 3'd2, 2'd0, 32'h0, 32'h0);
        tick();
        stall_i = 1'b1;
        tick();
        #2;
        rst = 1'b0;
        model_clear();
        #1;
        n_total++; if (wb_valid_o !== 1'b0 || wb_we_o !== 1'b0 || wb_rd_o !== 5'd0 ||
                       wb_data_o !== 32'h0 || instret_o !== '0)
            $display("FAIL rst_mid_stall got v%0b we%0b rd%0d d%h n%0d exp all 0",
                     wb_valid_o, wb_we_o, wb_rd_o, wb_data_o, instret_o);
        else n_pass++;
        @(negedge clk);
        set_idle();
        rst = 1'b1;
        #1;
        n_total++; if (wb_we_o !== 1'b0 || wb_valid_o !== 1'b0)
            $display("FAIL rst_release_we got we%0b v%0b exp 0/0", wb_we_o, wb_valid_o); else n_pass++;
        tick();
        n_total++; if (wb_we_o !== 1'b0 || wb_data_o !== 32'h0)
            $display("FAIL rst_first_cycle got we%0b d%h exp 0/0", wb_we_o, wb_data_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu();
        test_x0_write();
        test_stall();
        test_stall_flush();
        test_random();
        test_wrap();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data path width.
REQ-002 The block SHALL have parameter INSTRET_W, default 64, meaning the retired-instruction counter width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-low reset.
- stall_i, in, 1: hold the stage contents.
- flush_i, in, 1: squash the incoming instruction.
- valid_i, in, 1: an instruction is present from MEM.
- reg_write_i, in, 1: the instruction writes rd.
- rd_i, in, 5: destination register index.
- result_src_i, in, 2: result select; 00 ALU, 01 load, 10 PC+4, 11 immediate.
- funct3_i, in, 3: load size and sign.
- addr_lo_i, in, 2: load byte offset.
- alu_result_i, in, XLEN: ALU result.
- read_data_i, in, XLEN: raw data-memory word.
- pc_plus4_i, in, XLEN: link value.
- imm_i, in, XLEN: LUI immediate.
- wb_we_o, out, 1: register-file write enable.
- wb_rd_o, out, 5: register-file write address.
- wb_data_o, out, XLEN: register-file write data.
- wb_valid_o, out, 1: stage holds a valid instruction.
- instret_o, out, INSTRET_W: retired-instruction count.

Function
REQ-004 Every MEM-side input SHALL be captured on a rising clk edge when stall_i=0, giving exactly 1 cycle of latency to the outputs.
REQ-005 When flush_i=1 on an edge, the stage SHALL load a bubble (valid=0, we=0), and flush_i SHALL take priority over stall_i.
REQ-006 When stall_i=1 and flush_i=0, all stage registers SHALL hold their values, and the held write SHALL be re-presented on the outputs.
REQ-007 wb_we_o SHALL equal registered valid AND reg_write AND (rd != 0), so writes to x0 are never asserted.
REQ-008 Load extraction SHALL operate on read_data_i before capture, as follows:
- funct3 000 (LB) selects byte addr_lo and sign-extends it.
- funct3 100 (LBU) selects byte addr_lo and zero-extends it.
- funct3 001 (LH) selects halfword addr_lo[1] and sign-extends it; 101 (LHU) does the same with zero-extension.
- addr_lo[0] is ignored for halfwords.
- funct3 010 and all other codes pass the full word, ignoring addr_lo.
REQ-009 wb_data_o SHALL be the registered result selected by result_src, and SHALL be driven to 0 whenever wb_valid_o=0.
REQ-010 instret_o SHALL increment by 1 on each edge at which a valid, unstalled, unflushed instruction leaves the stage, regardless of reg_write.
REQ-011 instret_o SHALL wrap modulo 2^INSTRET_W with no sticky flag.

Reset
REQ-012 While rst=0, valid, we, rd, data and instret SHALL be cleared to 0 asynchronously.
REQ-013 Asserting rst mid-stall SHALL discard the held instruction, and no write SHALL occur in the first cycle after rst deasserts.

Configuration
REQ-014 With INSTRET_COUNTER_EN defined, the counter SHALL be implemented as specified in REQ-010 and REQ-011.
REQ-015 Without INSTRET_COUNTER_EN, instret_o SHALL be tied to 0 and no counter flops SHALL be present; all other behaviour SHALL be unchanged.

Structure
REQ-016 The shared package SHALL hold:
- the result_src encodings RES_ALU, RES_MEM, RES_PC4 and RES_IMM;
- the funct3 load codes F3_LB, F3_LH, F3_LW, F3_LBU and F3_LHU;
- the XLEN default.
REQ-017 Load alignment and extension SHALL be a separate combinational sub-module named load_extend.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- LB from word 0x80FF7F01, addr_lo=2 -> one cycle later wb_data_o=0xFFFFFFFF, wb_we_o=1, wb_rd_o=rd.
- LHU from 0x80FF7F01, addr_lo=3 -> wb_data_o=0x000080FF.
- ALU write with rd=0, alu_result=0x12345678 -> wb_we_o=0 while wb_valid_o=1, and instret increments.
- stall_i=1 for 3 cycles holding a write of 0xDEADBEEF to x5 -> outputs are stable for all 3 cycles and instret is unchanged until the stall releases.
- stall_i=1 with flush_i=1 -> the bubble is loaded, wb_we_o=0 and wb_data_o=0.
- instret preloaded near all-ones (INSTRET_W=4 build), one more retire -> instret_o=0; rst pulsed low mid-stall -> all outputs are 0 immediately.
